dual_port_ram_p: RTL and testbench
==================================

DUAL_PORT_RAM_P -- requirements
Module: dual_port_ram_p

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: data width of both ports, in bits.
REQ-002 SHALL provide parameter ADDR_W, default 10: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter RW_MODE, default 0: same-address read-during-write result; 0 = read-first (old data), 1 = write-first (new data).
REQ-004 Ports, as name, direction, width, meaning:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en1, en2  in  1  port enable; no operation when 0.
- rd_wr1, rd_wr2  in  1  1 = write, 0 = read; sampled only when the port's enable is 1.
- addr_1, addr_2  in  ADDR_W  port address.
- data_1, data_2  in  DATA_W  port write data.
- o1, o2  out  DATA_W  port read data.
- valid1, valid2  out  1  one-cycle pulse; oN holds newly read data.
- busy  out  1  clear in progress; all port operations are ignored.
- collision  out  1  one-cycle pulse on a same-address conflict.

Function
REQ-005 FSM SHALL have states CLEAR and RUN; rst forces CLEAR with clear pointer = 0.
REQ-006 CLEAR SHALL write 0 to one word per cycle (pointer 0..DEPTH-1), keep busy=1, ignore en1/en2, then go to RUN after pointer DEPTH-1 (busy drops the following cycle; DEPTH cycles total).
REQ-007 In RUN, accepted op = enN & !busy; write stores dataN at addr_N on that posedge.
REQ-008 Read SHALL have latency 1: oN updates and validN=1 on the cycle after acceptance; oN holds its value otherwise, including during writes.
REQ-009 Both ports SHALL operate independently and concurrently on different addresses.
REQ-010 Both ports writing the same address SHALL store port 1 data, discard port 2 data, and pulse collision one cycle later.
REQ-011 Read and write on the same address in one cycle SHALL return old data (RW_MODE=0) or the written data (RW_MODE=1), and pulse collision one cycle later.
REQ-012 Both ports reading the same address SHALL both return the data and SHALL NOT flag collision.
REQ-013 Address arithmetic SHALL be unsigned ADDR_W bits; the clear pointer SHALL use ADDR_W+1 bits so wrap is detected without an out-of-range write.

Reset
REQ-014 On rst: o1=o2=0, valid1=valid2=0, collision=0, busy=1 from the next cycle, state=CLEAR.
REQ-015 rst asserted mid-CLEAR SHALL restart clearing at address 0; rst mid-read SHALL suppress the pending validN.
REQ-016 Read/write requests during the rst cycle SHALL be discarded.

Configuration
REQ-017 Macro DPRAM_OUT_REG_EN defined: extra output register per port; read latency 2, validN and collision delayed to match, pipeline stage cleared by rst.
REQ-018 Macro DPRAM_OUT_REG_EN undefined: read latency 1 as REQ-008; no extra register present.

Structure
REQ-019 Shared package dpram_pkg SHALL hold the FSM state typedef (CLEAR, RUN) and the RW_MODE constants RW_READ_FIRST=0, RW_WRITE_FIRST=1.
REQ-020 One sub-module dpram_clear_ctrl (FSM, pointer, busy) SHALL be instantiated; storage and port logic stay in the top.

Verification
REQ-021 Reset then idle: busy=1 for exactly 1024 cycles (defaults); afterwards read addr 0x3FF on port 2 -> o2=0x00, valid2 pulse 1 cycle later.
REQ-022 Port 1 writes 0xA5 to addr 5; next cycle port 2 reads addr 5 -> o2=0xA5 one cycle later; o1 unchanged.
REQ-023 Both ports write addr 7 (0x11 on port 1, 0x22 on port 2) in one cycle -> collision pulse; a later read of addr 7 returns 0x11.
REQ-024 Addr 9 holds 0x33; port 1 writes 0x44 to it while port 2 reads it -> o2=0x33 (RW_MODE=0) or 0x44 (RW_MODE=1), collision=1.
REQ-025 rst pulsed at clear pointer 500, then port 1 writes during busy -> write ignored, busy lasts 1024 cycles from the new rst, all words read back 0.
REQ-026 With DPRAM_OUT_REG_EN: read issued at cycle t -> valid and data appear at t+2; back-to-back reads on consecutive cycles stream with one result per cycle.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types for the dual-port RAM: clear FSM states and
// read-during-write mode selectors.
package dpram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int RW_READ_FIRST  = 0;
   localparam int RW_WRITE_FIRST = 1;

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Power-up / reset clear sequencer: walks every word once, holding busy
// high until the last word has been zeroed.
module dpram_clear_ctrl
   import dpram_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   state_t          state;
   logic [ADDR_W:0] ptr;
   logic [ADDR_W:0] ptr_nxt;

   // The extra MSB flags the wrap past DEPTH-1 without ever addressing it.
   assign ptr_nxt  = ptr + {{ADDR_W{1'b0}}, 1'b1};
   assign clr_we   = (state == CLEAR);
   assign clr_addr = ptr[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
         busy  <= 1'b1;
      end else begin
         unique case (state)
            CLEAR: begin
               ptr <= ptr_nxt;
               if (ptr_nxt[ADDR_W]) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end
            end
            RUN: busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/dual_port_ram_p.sv
// True dual-port RAM with self-clearing after reset and collision flag.
// Optional macro DPRAM_OUT_REG_EN adds one output register stage per port.
module dual_port_ram_p
   import dpram_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 10,
   parameter int RW_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en1,
   input  logic              en2,
   input  logic              rd_wr1,
   input  logic              rd_wr2,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [DATA_W-1:0] data_1,
   input  logic [DATA_W-1:0] data_2,
   output logic [DATA_W-1:0] o1,
   output logic [DATA_W-1:0] o2,
   output logic              valid1,
   output logic              valid2,
   output logic              busy,
   output logic              collision
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   dpram_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic acc1, acc2, wr1, wr2, rd1, rd2;
   logic same, coll_now;
   logic [DATA_W-1:0] rdata1, rdata2;

   assign acc1     = en1 & ~busy & ~rst;
   assign acc2     = en2 & ~busy & ~rst;
   assign wr1      = acc1 & rd_wr1;
   assign wr2      = acc2 & rd_wr2;
   assign rd1      = acc1 & ~rd_wr1;
   assign rd2      = acc2 & ~rd_wr2;
   assign same     = (addr_1 == addr_2);
   assign coll_now = acc1 & acc2 & same & (rd_wr1 | rd_wr2);

   // Write-first forwards the other port's write data on an address match.
   assign rdata1 = (RW_MODE == RW_WRITE_FIRST && wr2 && same) ?
                   data_2 : mem[addr_1];
   assign rdata2 = (RW_MODE == RW_WRITE_FIRST && wr1 && same) ?
                   data_1 : mem[addr_2];

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         if (wr1)
            mem[addr_1] <= data_1;
         if (wr2 && !(wr1 && same))
            mem[addr_2] <= data_2;
      end
   end

   logic [DATA_W-1:0] q1, q2;
   logic              v1, v2, c1;

   always_ff @(posedge clk) begin
      if (rst) begin
         q1 <= '0;
         q2 <= '0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         c1 <= 1'b0;
      end else begin
         v1 <= rd1;
         v2 <= rd2;
         c1 <= coll_now;
         if (rd1)
            q1 <= rdata1;
         if (rd2)
            q2 <= rdata2;
      end
   end

`ifdef DPRAM_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o1        <= '0;
         o2        <= '0;
         valid1    <= 1'b0;
         valid2    <= 1'b0;
         collision <= 1'b0;
      end else begin
         valid1    <= v1;
         valid2    <= v2;
         collision <= c1;
         if (v1)
            o1 <= q1;
         if (v2)
            o2 <= q2;
      end
   end
`else
   assign o1        = q1;
   assign o2        = q2;
   assign valid1    = v1;
   assign valid2    = v2;
   assign collision = c1;
`endif

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Directed bench for dual_port_ram_p against a cycle-indexed behavioural
// model; honours DPRAM_OUT_REG_EN for the expected read latency.
module tb_dual_port_ram_p;

   localparam int DW      = 8;
   localparam int AW      = 10;
   localparam int DEPTH   = 1 << AW;
   localparam int RW_MODE = 0;
`ifdef DPRAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en1 = 1'b0, en2 = 1'b0;
   logic          rd_wr1 = 1'b0, rd_wr2 = 1'b0;
   logic [AW-1:0] addr_1 = '0, addr_2 = '0;
   logic [DW-1:0] data_1 = '0, data_2 = '0;
   logic [DW-1:0] o1, o2;
   logic          valid1, valid2, busy, collision;

   dual_port_ram_p #(.DATA_W(DW), .ADDR_W(AW), .RW_MODE(RW_MODE)) dut (
      .clk(clk), .rst(rst),
      .en1(en1), .en2(en2),
      .rd_wr1(rd_wr1), .rd_wr2(rd_wr2),
      .addr_1(addr_1), .addr_2(addr_2),
      .data_1(data_1), .data_2(data_2),
      .o1(o1), .o2(o2),
      .valid1(valid1), .valid2(valid2),
      .busy(busy), .collision(collision)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: memory contents plus results keyed by the edge they appear on.
   logic [DW-1:0] mmem [DEPTH];
   logic [DW-1:0] pv1 [int];
   logic [DW-1:0] pv2 [int];
   bit            pc  [int];
   int            cyc = 0;
   int            rst_edge = 0;
   bit            started = 0;
   logic [DW-1:0] exp_o1, exp_o2;
   logic          exp_v1, exp_v2, exp_c, exp_busy = 1'b1;

   task automatic model_edge();
      logic a1, a2;
      logic [DW-1:0] val;
      cyc++;
      if (rst) begin
         rst_edge = cyc;
         pv1.delete(); pv2.delete(); pc.delete();
         foreach (mmem[i]) mmem[i] = '0;
         exp_o1 = '0; exp_o2 = '0;
         exp_v1 = 0; exp_v2 = 0; exp_c = 0;
         exp_busy = 1;
         started = 1;
         return;
      end
      a1 = en1 && !exp_busy;
      a2 = en2 && !exp_busy;
      if (a1 && !rd_wr1) begin
         val = mmem[addr_1];
         if (RW_MODE == 1 && a2 && rd_wr2 && addr_2 == addr_1) val = data_2;
         pv1[cyc + LAT - 1] = val;
      end
      if (a2 && !rd_wr2) begin
         val = mmem[addr_2];
         if (RW_MODE == 1 && a1 && rd_wr1 && addr_1 == addr_2) val = data_1;
         pv2[cyc + LAT - 1] = val;
      end
      if (a1 && a2 && addr_1 == addr_2 && (rd_wr1 || rd_wr2))
         pc[cyc + LAT - 1] = 1;
      if (a2 && rd_wr2) mmem[addr_2] = data_2;
      if (a1 && rd_wr1) mmem[addr_1] = data_1;
      exp_v1 = pv1.exists(cyc);
      if (exp_v1) begin exp_o1 = pv1[cyc]; pv1.delete(cyc); end
      exp_v2 = pv2.exists(cyc);
      if (exp_v2) begin exp_o2 = pv2[cyc]; pv2.delete(cyc); end
      exp_c = pc.exists(cyc);
      if (exp_c) pc.delete(cyc);
      exp_busy = (cyc - rst_edge) < DEPTH;
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("busy", 32'(busy), 32'(exp_busy));
         check("valid1", 32'(valid1), 32'(exp_v1));
         check("valid2", 32'(valid2), 32'(exp_v2));
         check("collision", 32'(collision), 32'(exp_c));
         check("o1", 32'(o1), 32'(exp_o1));
         check("o2", 32'(o2), 32'(exp_o2));
      end
   end

   task automatic step(input logic r,
                       input logic e1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic e2, input logic w2,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2);
      rst = r;
      en1 = e1; rd_wr1 = w1; addr_1 = a1; data_1 = d1;
      en2 = e2; rd_wr2 = w2; addr_2 = a2; data_2 = d2;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic wait_clear(output int n);
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
         n++;
         idle(1);
      end
   endtask

   initial begin
      int n;
      logic [DW-1:0] exp_rw;

      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      check("rst_o1", 32'(o1), 0);
      check("rst_valid", 32'({valid1, valid2, collision}), 0);
      wait_clear(n);
      check("busy_len", n, 1024);

      // Top word reads back as cleared.
      step(0, 0, 0, '0, '0, 1, 0, 10'h3FF, '0);
      idle(LAT - 1);
      check("rd3ff_v", 32'(valid2), 1);
      check("rd3ff_o", 32'(o2), 0);
      idle(1);
      check("rd3ff_pulse", 32'(valid2), 0);

      // Cross-port write then read.
      step(0, 1, 1, 10'd5, 8'hA5, 0, 0, '0, '0);
      step(0, 0, 0, '0, '0, 1, 0, 10'd5, '0);
      idle(LAT - 1);
      check("wr5_o2", 32'(o2), 32'h A5);
      check("wr5_v2", 32'(valid2), 1);
      check("wr5_o1", 32'(o1), 0);

      // Double write to one address: port 1 wins.
      step(0, 1, 1, 10'd7, 8'h11, 1, 1, 10'd7, 8'h22);
      idle(LAT - 1);
      check("ww7_coll", 32'(collision), 1);
      idle(1);
      check("ww7_pulse", 32'(collision), 0);
      step(0, 1, 0, 10'd7, '0, 0, 0, '0, '0);
      idle(LAT - 1);
      check("ww7_o1", 32'(o1), 32'h11);

      // Read-during-write on addr 9.
      step(0, 1, 1, 10'd9, 8'h33, 0, 0, '0, '0);
      step(0, 1, 1, 10'd9, 8'h44, 1, 0, 10'd9, '0);
      idle(LAT - 1);
      exp_rw = (RW_MODE == 1) ? 8'h44 : 8'h33;
      check("rw9_o2", 32'(o2), 32'(exp_rw));
      check("rw9_coll", 32'(collision), 1);

      // Dual read same address: data on both, no collision.
      step(0, 1, 0, 10'd9, '0, 1, 0, 10'd9, '0);
      idle(LAT - 1);
      check("rr9_o1", 32'(o1), 32'h44);
      check("rr9_o2", 32'(o2), 32'h44);
      check("rr9_coll", 32'(collision), 0);

      // Concurrent independent reads.
      step(0, 1, 0, 10'd5, '0, 1, 0, 10'd7, '0);
      idle(LAT);

      // Reset immediately after a read kills its valid.
      step(0, 1, 0, 10'd5, '0, 0, 0, '0, '0);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      check("rstrd_v1", 32'(valid1), 0);
      check("rstrd_o1", 32'(o1), 0);

      // Restart clear mid-way, write while busy is ignored.
      idle(500);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      step(0, 1, 1, 10'd5, 8'hFF, 1, 1, 10'd6, 8'hEE);
      wait_clear(n);
      check("busy_len2", n + 1, 1024);
      for (int i = 0; i < DEPTH / 2; i++)
         step(0, 1, 0, AW'(i), '0, 1, 0, AW'(i + DEPTH / 2), '0);
      idle(LAT);
      step(0, 1, 0, 10'd5, '0, 1, 0, 10'd6, '0);
      idle(LAT - 1);
      check("busywr_o1", 32'(o1), 0);
      check("busywr_o2", 32'(o2), 0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
